// File: rtl/memory_arbiter_pkg.sv
// Shared encodings and default parameters for the single-port memory arbiter.
package memory_arbiter_pkg;

  localparam logic ACC_READ  = 1'b0;
  localparam logic ACC_WRITE = 1'b1;

  localparam int DEF_STARVE_LIMIT   = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_BUSY_FETCH = 2'd1,
    ARB_BUSY_DATA  = 2'd2
  } arb_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/memory_watchdog.sv
// Busy-cycle watchdog: expired is high during the TIMEOUT_CYCLES-th consecutive busy cycle.
module memory_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Count completed busy cycles since the last grant, holding at the expiry point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (count_enable && (count_r != LAST)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = count_enable && (count_r == LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, with data priority,
// a starvation guard for fetch and a watchdog that aborts unanswered accesses.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_request,
  input  logic [31:0] fetch_address,
  output logic        fetch_accept,
  output logic        fetch_done,
  output logic [31:0] fetch_data,
  input  logic        data_request,
  input  logic        data_state,
  input  logic [31:0] data_address,
  input  logic [3:0]  data_frame_mask,
  input  logic [31:0] data_store_data,
  output logic        data_accept,
  output logic        data_done,
  output logic [31:0] data_load_data,
  output logic        memory_enable,
  output logic        memory_state,
  output logic [31:0] memory_address,
  output logic [3:0]  memory_frame_mask,
  output logic [31:0] memory_write_data,
  input  logic [31:0] memory_read_data,
  input  logic        memory_ack,
  output logic        bus_error,
  output logic        error_source
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state_r;
  logic [SW-1:0] starve_r;
  logic          grant_fetch_s;
  logic          grant_data_s;
  logic          wd_expired_s;

  // Pick a winner while idle; fetch pre-empts data only once it has been starved.
  always_comb begin
    grant_fetch_s = 1'b0;
    grant_data_s  = 1'b0;
    if (state_r == ARB_IDLE) begin
      if (fetch_request && (starve_r == STARVE_MAX)) begin
        grant_fetch_s = 1'b1;
      end else if (data_request) begin
        grant_data_s = 1'b1;
      end else if (fetch_request) begin
        grant_fetch_s = 1'b1;
      end else begin
        grant_fetch_s = 1'b0;
        grant_data_s  = 1'b0;
      end
    end else begin
      grant_fetch_s = 1'b0;
      grant_data_s  = 1'b0;
    end
  end

  memory_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .clear       (grant_fetch_s | grant_data_s),
    .count_enable(state_r != ARB_IDLE),
    .expired     (wd_expired_s)
  );

  // Arbiter FSM: grants, memory port registers, completion and error pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r           <= ARB_IDLE;
      starve_r          <= {SW{1'b0}};
      fetch_accept      <= 1'b0;
      fetch_done        <= 1'b0;
      fetch_data        <= 32'h0000_0000;
      data_accept       <= 1'b0;
      data_done         <= 1'b0;
      data_load_data    <= 32'h0000_0000;
      memory_enable     <= 1'b0;
      memory_state      <= ACC_READ;
      memory_address    <= 32'h0000_0000;
      memory_frame_mask <= 4'b0000;
      memory_write_data <= 32'h0000_0000;
      bus_error         <= 1'b0;
      error_source      <= 1'b0;
    end else begin
      fetch_accept <= 1'b0;
      fetch_done   <= 1'b0;
      data_accept  <= 1'b0;
      data_done    <= 1'b0;
      bus_error    <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          if (grant_fetch_s) begin
            memory_enable     <= 1'b1;
            memory_state      <= ACC_READ;
            memory_address    <= word_align(fetch_address);
            memory_frame_mask <= 4'b1111;
            memory_write_data <= 32'h0000_0000;
            fetch_accept      <= 1'b1;
            starve_r          <= {SW{1'b0}};
            state_r           <= ARB_BUSY_FETCH;
          end else if (grant_data_s) begin
            memory_enable     <= 1'b1;
            memory_state      <= data_state;
            memory_address    <= word_align(data_address);
            memory_frame_mask <= data_frame_mask;
            memory_write_data <= (data_state == ACC_WRITE) ? data_store_data : 32'h0000_0000;
            data_accept       <= 1'b1;
            starve_r          <= fetch_request ? (starve_r + SW'(1)) : {SW{1'b0}};
            state_r           <= ARB_BUSY_DATA;
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_BUSY_FETCH: begin
          if (memory_ack) begin
            fetch_data    <= memory_read_data;
            fetch_done    <= 1'b1;
            memory_enable <= 1'b0;
            state_r       <= ARB_IDLE;
          end else if (wd_expired_s) begin
            bus_error     <= 1'b1;
            error_source  <= 1'b0;
            fetch_done    <= 1'b1;
            memory_enable <= 1'b0;
            state_r       <= ARB_IDLE;
          end else begin
            state_r <= ARB_BUSY_FETCH;
          end
        end
        ARB_BUSY_DATA: begin
          if (memory_ack) begin
            if (memory_state == ACC_READ) begin
              data_load_data <= memory_read_data;
            end else begin
              data_load_data <= data_load_data;
            end
            data_done     <= 1'b1;
            memory_enable <= 1'b0;
            state_r       <= ARB_IDLE;
          end else if (wd_expired_s) begin
            bus_error     <= 1'b1;
            error_source  <= 1'b1;
            data_done     <= 1'b1;
            memory_enable <= 1'b0;
            state_r       <= ARB_IDLE;
          end else begin
            state_r <= ARB_BUSY_DATA;
          end
        end
        default: begin
          memory_enable <= 1'b0;
          state_r       <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: LW, contention, SB write, timeout, collision, mid-access reset.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_request;
  logic [31:0] fetch_address;
  logic        fetch_accept;
  logic        fetch_done;
  logic [31:0] fetch_data;
  logic        data_request;
  logic        data_state;
  logic [31:0] data_address;
  logic [3:0]  data_frame_mask;
  logic [31:0] data_store_data;
  logic        data_accept;
  logic        data_done;
  logic [31:0] data_load_data;
  logic        memory_enable;
  logic        memory_state;
  logic [31:0] memory_address;
  logic [3:0]  memory_frame_mask;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;
  logic        memory_ack;
  logic        bus_error;
  logic        error_source;

  int tests_run    = 0;
  int tests_failed = 0;

  memory_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_request    (fetch_request),
    .fetch_address    (fetch_address),
    .fetch_accept     (fetch_accept),
    .fetch_done       (fetch_done),
    .fetch_data       (fetch_data),
    .data_request     (data_request),
    .data_state       (data_state),
    .data_address     (data_address),
    .data_frame_mask  (data_frame_mask),
    .data_store_data  (data_store_data),
    .data_accept      (data_accept),
    .data_done        (data_done),
    .data_load_data   (data_load_data),
    .memory_enable    (memory_enable),
    .memory_state     (memory_state),
    .memory_address   (memory_address),
    .memory_frame_mask(memory_frame_mask),
    .memory_write_data(memory_write_data),
    .memory_read_data (memory_read_data),
    .memory_ack       (memory_ack),
    .bus_error        (bus_error),
    .error_source     (error_source)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] grant_log;
    int         grants;
    int         overlap;
    int         early_err;

    reset = 1'b0;
    fetch_request = 1'b0; fetch_address = 32'h0;
    data_request = 1'b0; data_state = 1'b0; data_address = 32'h0;
    data_frame_mask = 4'h0; data_store_data = 32'h0;
    memory_read_data = 32'h0; memory_ack = 1'b0;
    #12;
    check_eq("reset_ctrl", {26'h0, memory_enable, fetch_accept, data_accept, fetch_done, data_done, bus_error}, 32'h0);
    check_eq("reset_addr", memory_address, 32'h0);
    reset = 1'b1;
    tick();

    // Single LW, ack in first busy cycle
    data_request = 1'b1; data_state = 1'b0; data_address = 32'h1000_0006; data_frame_mask = 4'b1111;
    tick();
    check_eq("lw_accept", {30'h0, data_accept, memory_enable}, 32'h3);
    check_eq("lw_addr", memory_address, 32'h1000_0004);
    check_eq("lw_mask_state", {27'h0, memory_frame_mask, memory_state}, {27'h0, 4'b1111, 1'b0});
    data_request = 1'b0; memory_ack = 1'b1; memory_read_data = 32'hDEAD_BEEF;
    tick();
    check_eq("lw_done", {29'h0, data_done, data_accept, memory_enable}, 32'h4);
    check_eq("lw_load", data_load_data, 32'hDEAD_BEEF);
    memory_ack = 1'b0;
    tick();
    check_eq("lw_done_clr", {31'h0, data_done}, 32'h0);

    // Contention: both requesting, immediate ack
    fetch_request = 1'b1; fetch_address = 32'h0000_0200;
    data_request = 1'b1; data_address = 32'h1000_0100;
    memory_ack = 1'b1; memory_read_data = 32'hCAFE_0001;
    grant_log = 10'h0; grants = 0; overlap = 0;
    for (int i = 0; i < 100 && grants < 10; i++) begin
      tick();
      if ((fetch_accept && fetch_done) || (data_accept && data_done) || (fetch_accept && data_accept)) overlap++;
      if (data_accept) begin grant_log = {grant_log[8:0], 1'b1}; grants++; end
      if (fetch_accept) begin grant_log = {grant_log[8:0], 1'b0}; grants++; end
    end
    fetch_request = 1'b0; data_request = 1'b0;
    tick();
    memory_ack = 1'b0;
    check_eq("cont_grants", grants, 32'd10);
    check_eq("cont_order", {22'h0, grant_log}, {22'h0, 10'b11110_11110});
    check_eq("cont_overlap", overlap, 32'd0);
    check_eq("cont_fetch_data", fetch_data, 32'hCAFE_0001);
    tick();

    // SB write, ack in third busy cycle
    data_request = 1'b1; data_state = 1'b1; data_address = 32'h2000_0010;
    data_frame_mask = 4'b0010; data_store_data = 32'h0000_5A00;
    memory_read_data = 32'hBAD0_BAD0;
    tick();
    check_eq("sb_accept_state", {29'h0, data_accept, memory_enable, memory_state}, 32'h7);
    check_eq("sb_mask", {28'h0, memory_frame_mask}, 32'h2);
    data_request = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      check_eq($sformatf("sb_wdata_c%0d", c), memory_write_data, 32'h0000_5A00);
      check_eq($sformatf("sb_busy_c%0d", c), {30'h0, memory_enable, data_done}, 32'h2);
    end
    memory_ack = 1'b1;
    tick();
    memory_ack = 1'b0;
    check_eq("sb_done", {30'h0, data_done, memory_enable}, 32'h2);
    check_eq("sb_load_kept", data_load_data, 32'hCAFE_0001);
    tick();
    check_eq("sb_done_clr", {31'h0, data_done}, 32'h0);

    // Fetch timeout
    fetch_request = 1'b1; fetch_address = 32'h0000_0103;
    tick();
    check_eq("to_accept", {31'h0, fetch_accept}, 32'h1);
    check_eq("to_addr", memory_address, 32'h0000_0100);
    fetch_request = 1'b0;
    early_err = 0;
    for (int c = 2; c <= 16; c++) begin
      tick();
      if (bus_error || fetch_done) early_err++;
    end
    check_eq("to_no_early", early_err, 32'd0);
    tick();
    check_eq("to_error", {29'h0, bus_error, error_source, fetch_done}, 32'h5);
    check_eq("to_fetch_kept", fetch_data, 32'hCAFE_0001);
    tick();
    check_eq("to_err_clr", {30'h0, bus_error, fetch_done}, 32'h0);
    data_request = 1'b1; data_state = 1'b0; data_address = 32'h3000_0000; data_frame_mask = 4'b1111;
    tick();
    check_eq("to_next_accept", {31'h0, data_accept}, 32'h1);
    data_request = 1'b0; memory_ack = 1'b1; memory_read_data = 32'h0BAD_F00D;
    tick();
    memory_ack = 1'b0;
    check_eq("to_next_done", {31'h0, data_done}, 32'h1);
    check_eq("to_next_load", data_load_data, 32'h0BAD_F00D);
    tick();

    // Ack arrives in the cycle the watchdog expires
    fetch_request = 1'b1; fetch_address = 32'h0000_0040;
    tick();
    fetch_request = 1'b0;
    for (int c = 2; c <= 16; c++) tick();
    memory_ack = 1'b1; memory_read_data = 32'h600D_DA7A;
    tick();
    memory_ack = 1'b0;
    check_eq("col_no_error", {30'h0, bus_error, fetch_done}, 32'h1);
    check_eq("col_fetch_data", fetch_data, 32'h600D_DA7A);
    tick();

    // Reset in the second busy cycle of a data access
    data_request = 1'b1; data_state = 1'b0; data_address = 32'h5000_0008; data_frame_mask = 4'b1111;
    tick();
    data_request = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst_mid_ctrl", {28'h0, memory_enable, data_accept, data_done, bus_error}, 32'h0);
    check_eq("rst_mid_addr", memory_address, 32'h0);
    check_eq("rst_mid_data", data_load_data | fetch_data, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("rst_no_done", {30'h0, data_done, memory_enable}, 32'h0);
    data_request = 1'b1;
    tick();
    check_eq("rst_retry_accept", {30'h0, data_accept, memory_enable}, 32'h3);
    data_request = 1'b0; memory_ack = 1'b1; memory_read_data = 32'h1234_5678;
    tick();
    memory_ack = 1'b0;
    check_eq("rst_retry_done", {31'h0, data_done}, 32'h1);
    check_eq("rst_retry_load", data_load_data, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Single-port memory arbiter sharing one memory interface between the instruction-fetch path and the load/store unit. It latches one request at a time, drives the memory interface until the memory acknowledges or a watchdog expires, and returns read data and a completion pulse to the winning requester. Data accesses have priority, and a starvation limit guarantees that fetch always progresses. It sits between the core's fetch/LSU front ends and the external memory port.

## Interface
- `STARVE_LIMIT`, 4: maximum consecutive data grants while a fetch is pending; the next grant is forced to fetch.
- `TIMEOUT_CYCLES`, 16: number of busy cycles without `memory_ack` before the access is aborted.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `fetch_request` in 1: fetch request; held until `fetch_accept`.
- `fetch_address` in 32: fetch word address; bits [1:0] are ignored.
- `fetch_accept` out 1: one-cycle pulse when the fetch request is latched.
- `fetch_done` out 1: one-cycle pulse when fetch data is valid.
- `fetch_data` out 32: instruction word; holds its value until the next fetch completes.
- `data_request` in 1: LSU request; held until `data_accept`.
- `data_state` in 1: 0 = READ, 1 = WRITE.
- `data_address` in 32: word-aligned address from the LSU.
- `data_frame_mask` in 4: byte-lane mask from the LSU.
- `data_store_data` in 32: write data, already lane-aligned.
- `data_accept` out 1: one-cycle pulse when the LSU request is latched.
- `data_done` out 1: one-cycle pulse when the LSU access completes (read or write).
- `data_load_data` out 32: raw read word; updated only by READ completions.
- `memory_enable` out 1: access active.
- `memory_state` out 1: READ/WRITE.
- `memory_address` out 32: `{addr[31:2],2'b00}`.
- `memory_frame_mask` out 4: byte lanes; 4'b1111 for fetch.
- `memory_write_data` out 32: write data; 0 during reads.
- `memory_read_data` in 32: read data; valid in the cycle `memory_ack` is high.
- `memory_ack` in 1: access complete; may be high in the first busy cycle.
- `bus_error` out 1: one-cycle pulse on timeout.
- `error_source` out 1: 0 = fetch, 1 = data; valid with `bus_error`.

## Operation
- States:
  - IDLE: no access in progress.
  - BUSY_FETCH: fetch access driven on the memory port.
  - BUSY_DATA: LSU access driven on the memory port.
- Arbitration in IDLE, evaluated each cycle:
  - Data wins over fetch unless `starve_count == STARVE_LIMIT` with `fetch_request` high; then fetch wins.
  - `starve_count` increments on each data grant made while `fetch_request` is high.
  - `starve_count` clears on any fetch grant, or on a data grant made while `fetch_request` is low.
  - Saturating, width `$clog2(STARVE_LIMIT+1)`.
- Grant edge (IDLE, winner found):
  - Register address, mask, state and write data into the memory outputs.
  - Pulse the winner's `*_accept` in the following cycle.
  - Move to BUSY_x.
  - The loser keeps its request asserted.
- BUSY_x with `memory_ack` = 1:
  - Capture `memory_read_data` into `fetch_data` (fetch) or `data_load_data` (data READ).
  - Pulse `*_done` next cycle.
  - Deassert `memory_enable`.
  - Return to IDLE.
- BUSY_x without ack:
  - The watchdog counts busy cycles.
  - When the count reaches `TIMEOUT_CYCLES`: pulse `bus_error`, set `error_source`, pulse `*_done` with the data register unchanged, return to IDLE.
  - The watchdog clears on every grant.
- WRITE completion: `data_done` pulses; `data_load_data` is unchanged.
- `memory_ack` while IDLE is ignored.

## Timing
- Reset (asynchronous, immediate), including mid-access:
  - State = IDLE; all counters = 0.
  - All outputs = 0: `memory_enable`, `memory_state`, `memory_address`, `memory_frame_mask`, `memory_write_data`, accepts, dones, `fetch_data`, `data_load_data`, `bus_error`, `error_source`.
  - An in-flight access is dropped with no `done` pulse.
- Latency:
  - Request seen in cycle 0 → `memory_enable` and `*_accept` in cycle 1.
  - Ack in cycle 1 → `*_done` in cycle 2, state IDLE in cycle 2.
  - The next grant can occur at the edge ending cycle 2.
  - Minimum 2 cycles between back-to-back grants.
- Memory outputs are registered and stable for the whole BUSY period.
- Simultaneous timeout and ack in the same cycle: ack wins; no error.
- Every `*_done` pulse is exactly one cycle; `*_accept` and `*_done` never coincide for the same requester.

## Structure
- The shared defines header gets:
  - READ/WRITE encodings.
  - State encodings `ARB_IDLE`, `ARB_BUSY_FETCH`, `ARB_BUSY_DATA`.
  - Default `STARVE_LIMIT` and `TIMEOUT_CYCLES`.
- One sub-module, `memory_watchdog`:
  - Ports: clear, count-enable, expired.
  - Counter width `$clog2(TIMEOUT_CYCLES+1)`.
- The grant logic, starvation counter and response registers stay in `memory_arbiter`.

## Test plan
- **Single LW:** `data_request` READ at 0x1000_0006, mask 4'b1111, memory acks in its first busy cycle with 0xDEADBEEF → `memory_address` = 0x1000_0004; `data_accept` cycle 1, `data_done` cycle 2, `data_load_data` = 0xDEADBEEF.
- **Contention:** fetch and data both requesting continuously, ack always immediate, `STARVE_LIMIT`=4 → grant order D,D,D,D,F,D,D,D,D,F; fetch never waits more than 4 grants.
- **SB write:** WRITE, mask 4'b0010, data 0x0000_5A00, ack after 3 cycles → `memory_write_data` = 0x0000_5A00 held for 3 cycles; `data_done` one cycle; `data_load_data` unchanged.
- **Timeout:** fetch with no ack → `bus_error` pulses exactly `TIMEOUT_CYCLES` cycles after `fetch_accept`, with `error_source` = 0, `fetch_done` = 1 and `fetch_data` unchanged; a subsequent data request is served normally.
- **Ack/timeout collision:** ack asserted in the cycle the watchdog expires → no `bus_error`; read data captured.
- **Reset mid-access:** `reset` driven low in cycle 2 of a BUSY_DATA → all outputs 0 immediately, no `data_done`; after release an identical request is served with standard latency.
